// File: rtl/alu_result_queue.sv
// alu_result_queue: in-order FIFO between the ALU result port and writeback.
// Ports: clk_i, rst_ni, flush_i; alu_* push side (valid/ready, trans_id,
//   result, branch_res); wb_* pop side (valid/ready, trans_id, result,
//   branch_res); count_o reports occupied entries.
module alu_result_queue #(
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned XLEN          = 64,
    parameter int unsigned TRANS_ID_BITS = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       alu_valid_i,
    output logic                       alu_ready_o,
    input  logic [TRANS_ID_BITS-1:0]   alu_trans_id_i,
    input  logic [XLEN-1:0]            alu_result_i,
    input  logic                       alu_branch_res_i,
    output logic                       wb_valid_o,
    input  logic                       wb_ready_i,
    output logic [TRANS_ID_BITS-1:0]   wb_trans_id_o,
    output logic [XLEN-1:0]            wb_result_o,
    output logic                       wb_branch_res_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]         r_wr_ptr;
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [CNT_W-1:0]         r_count;

    logic [XLEN-1:0]          r_res_mem [DEPTH];
    logic [TRANS_ID_BITS-1:0] r_id_mem  [DEPTH];
    logic                     r_br_mem  [DEPTH];

    logic w_ready;
    logic w_valid;
    logic w_push;
    logic w_pop;

    // Both flags come from registered occupancy only, so there is no
    // combinational path from wb_ready_i to alu_ready_o.
    assign w_ready = (r_count != FULL_CNT);
    assign w_valid = (r_count != '0);
    assign w_push  = alu_valid_i & w_ready;
    assign w_pop   = w_valid & wb_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage carries no reset; a flushed push never writes.
    always_ff @(posedge clk_i) begin
        if (w_push && !flush_i) begin
            r_res_mem[r_wr_ptr] <= alu_result_i;
            r_id_mem[r_wr_ptr]  <= alu_trans_id_i;
            r_br_mem[r_wr_ptr]  <= alu_branch_res_i;
        end
    end

    // Data is masked while empty so unreset storage never leaks out.
    always_comb begin
        wb_trans_id_o   = '0;
        wb_result_o     = '0;
        wb_branch_res_o = 1'b0;
        if (w_valid) begin
            wb_trans_id_o   = r_id_mem[r_rd_ptr];
            wb_result_o     = r_res_mem[r_rd_ptr];
            wb_branch_res_o = r_br_mem[r_rd_ptr];
        end
    end

    assign alu_ready_o = w_ready;
    assign wb_valid_o  = w_valid;
    assign count_o     = r_count;

endmodule

// File: tb/tb_alu_result_queue.sv
// tb_alu_result_queue: random + directed scoreboard bench for alu_result_queue.
// Reference model is a plain queue of accepted results, capacity DEPTH.
module tb_alu_result_queue;

    localparam int DEPTH = 4;

    typedef struct {
        logic [2:0]  id;
        logic [63:0] res;
        logic        br;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        alu_valid = 1'b0;
    logic        alu_ready;
    logic [2:0]  alu_id = '0;
    logic [63:0] alu_res = '0;
    logic        alu_br = 1'b0;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [2:0]  wb_id;
    logic [63:0] wb_res;
    logic        wb_br;
    logic [2:0]  count;

    int n_vec = 0;
    int n_err = 0;

    ent_t sb[$];
    bit   do_pop;
    bit   do_push;

    alu_result_queue #(
        .DEPTH(DEPTH), .XLEN(64), .TRANS_ID_BITS(3)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .flush_i          (flush),
        .alu_valid_i      (alu_valid),
        .alu_ready_o      (alu_ready),
        .alu_trans_id_i   (alu_id),
        .alu_result_i     (alu_res),
        .alu_branch_res_i (alu_br),
        .wb_valid_o       (wb_valid),
        .wb_ready_i       (wb_ready),
        .wb_trans_id_o    (wb_id),
        .wb_result_o      (wb_res),
        .wb_branch_res_o  (wb_br),
        .count_o          (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: accepted results queue in order; flush and reset empty it.
    always @(negedge rst_n) sb.delete();

    always @(posedge clk) begin
        if (rst_n) begin
            if (flush) begin
                sb.delete();
            end else begin
                do_pop  = (sb.size() != 0) && wb_ready;
                do_push = alu_valid && (sb.size() != DEPTH);
                if (do_pop) void'(sb.pop_front());
                if (do_push) sb.push_back('{alu_id, alu_res, alu_br});
            end
        end
    end

    // Monitor: compare DUT outputs with the model head mid-cycle.
    always @(negedge clk) begin
        check("count", 64'(count), 64'(sb.size()));
        check("alu_ready", 64'(alu_ready), 64'(sb.size() != DEPTH));
        check("wb_valid", 64'(wb_valid), 64'(sb.size() != 0));
        if (sb.size() != 0 && wb_valid) begin
            check("wb_id", 64'(wb_id), 64'(sb[0].id));
            check("wb_res", wb_res, sb[0].res);
            check("wb_br", 64'(wb_br), 64'(sb[0].br));
        end
    end

    task automatic step(input logic v, input logic [2:0] id,
                        input logic [63:0] r, input logic b,
                        input logic rdy, input logic fl);
        @(negedge clk);
        #1;
        alu_valid = v;
        alu_id    = id;
        alu_res   = r;
        alu_br    = b;
        wb_ready  = rdy;
        flush     = fl;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 3'd0, 64'd0, 1'b0, rdy, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        alu_valid = 1'b0;
        wb_ready = 1'b0;
        flush = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", 64'(wb_valid), 64'd0);
        check("rst_ready", 64'(alu_ready), 64'd1);
        check("rst_count", 64'(count), 64'd0);
        check("rst_res", wb_res, 64'd0);
        check("rst_id", 64'(wb_id), 64'd0);
        #1 rst_n = 1'b1;

        // single result
        step(1'b1, 3'd2, 64'h5, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // fill to full, offer a fifth, pop while full with valid asserted
        for (int i = 0; i < 4; i++)
            step(1'b1, 3'(i), 64'(100 + i), i[0], 1'b0, 1'b0);
        step(1'b1, 3'd4, 64'h444, 1'b1, 1'b0, 1'b0);
        step(1'b1, 3'd5, 64'h555, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) idle(1'b1);

        // streaming with wrap-around
        for (int i = 0; i < 10; i++)
            step(1'b1, 3'(i % 8), {$urandom, $urandom}, 1'($urandom), 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // back-pressure stability
        step(1'b1, 3'd6, 64'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) idle(1'b0);
        idle(1'b1);
        idle(1'b1);

        // flush versus push
        for (int i = 0; i < 3; i++)
            step(1'b1, 3'(i), 64'(200 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'd7, 64'h7777, 1'b1, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // async reset mid-stream
        for (int i = 0; i < 2; i++)
            step(1'b1, 3'(i), 64'(300 + i), 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(wb_valid), 64'd0);
        check("arst_count", 64'(count), 64'd0);
        check("arst_ready", 64'(alu_ready), 64'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        // randomized traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) != 0), 3'($urandom),
                 {$urandom, $urandom}, 1'($urandom),
                 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 40) == 0));
        for (int i = 0; i < 6; i++) idle(1'b1);
        do_reset();
        idle(1'b0);
        idle(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
